// File: rtl/xbar_pkg.sv
// Shared index-width helpers and index types for the destination-routed crossbar.
package xbar_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int dw_o(input int num_output);
        return idx_width(num_output);
    endfunction

    function automatic int dw_i(input int num_input);
        return idx_width(num_input);
    endfunction

    // Index types for the default 4x4 configuration.
    localparam int DEF_NUM_INPUT  = 4;
    localparam int DEF_NUM_OUTPUT = 4;

    typedef logic [dw_o(DEF_NUM_OUTPUT)-1:0] out_idx_t;
    typedef logic [dw_i(DEF_NUM_INPUT)-1:0]  in_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first request at or after the pointer wins; the pointer
// moves past the winner only when the grant is actually consumed.
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int PW = idx_width(NUM_REQ);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] gnt_idx;
    logic          found;
    int            idx;

    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_reg) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx[PW-1:0]]) begin
                found                = 1'b1;
                gnt_idx              = idx[PW-1:0];
                gnt_o[idx[PW-1:0]]   = 1'b1;
            end
        end
    end

    assign ptr_next = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg <= '0;
        end else if (advance_i && found) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/dest_routed_xbar.sv
// Destination-routed crossbar: each output arbitrates round-robin among the inputs
// that target it and registers the winner into a one-entry output stage.
module dest_routed_xbar
    import xbar_pkg::*;
#(
    parameter  int NUM_INPUT  = 4,
    parameter  int NUM_OUTPUT = 4,
    parameter  int DATA_WIDTH = 4,
    localparam int DW_O       = dw_o(NUM_OUTPUT),
    localparam int DW_I       = dw_i(NUM_INPUT)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_INPUT-1:0][DATA_WIDTH-1:0]  input_vector_i,
    input  logic [NUM_INPUT-1:0][DW_O-1:0]        input_dest_i,
    input  logic [NUM_INPUT-1:0]                  input_valid_i,
    output logic [NUM_INPUT-1:0]                  input_ready_o,
    output logic [NUM_OUTPUT-1:0][DATA_WIDTH-1:0] output_vector_o,
    output logic [NUM_OUTPUT-1:0][DW_I-1:0]       output_src_o,
    output logic [NUM_OUTPUT-1:0]                 output_valid_o,
    input  logic [NUM_OUTPUT-1:0]                 output_ready_i,
    output logic [NUM_INPUT-1:0]                  drop_o
);

    logic [NUM_OUTPUT-1:0][NUM_INPUT-1:0] ready_mat;
    logic [NUM_INPUT-1:0]                 drop_req;

    genvar gi, gj;

    for (gj = 0; gj < NUM_OUTPUT; gj++) begin : g_out
        logic [NUM_INPUT-1:0]  req;
        logic [NUM_INPUT-1:0]  gnt;
        logic                  load;
        logic                  accept;
        logic [DATA_WIDTH-1:0] win_vector;
        logic [DW_I-1:0]       win_src;
        logic                  valid_reg;
        logic [DATA_WIDTH-1:0] vector_reg;
        logic [DW_I-1:0]       src_reg;

        for (gi = 0; gi < NUM_INPUT; gi++) begin : g_req
            assign req[gi] = input_valid_i[gi] && (input_dest_i[gi] == DW_O'(gj));
        end

        // Loading while the current entry leaves gives full-throughput pass-through.
        assign load   = !rst_i && (!valid_reg || output_ready_i[gj]);
        assign accept = load && (|gnt);

        rr_arbiter #(
            .NUM_REQ (NUM_INPUT)
        ) u_arb (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .req_i     (req),
            .advance_i (accept),
            .gnt_o     (gnt)
        );

        assign ready_mat[gj] = load ? gnt : '0;

        always_comb begin
            win_vector = '0;
            win_src    = '0;
            for (int k = 0; k < NUM_INPUT; k++) begin
                if (gnt[k]) begin
                    win_vector = input_vector_i[k];
                    win_src    = DW_I'(k);
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_reg  <= 1'b0;
                vector_reg <= '0;
                src_reg    <= '0;
            end else if (accept) begin
                valid_reg  <= 1'b1;
                vector_reg <= win_vector;
                src_reg    <= win_src;
            end else if (output_ready_i[gj]) begin
                valid_reg  <= 1'b0;
            end
        end

        assign output_valid_o[gj]  = valid_reg;
        assign output_vector_o[gj] = vector_reg;
        assign output_src_o[gj]    = src_reg;
    end

    // Out-of-range destinations only exist when NUM_OUTPUT leaves index codes unused.
    for (gi = 0; gi < NUM_INPUT; gi++) begin : g_drop
        if (NUM_OUTPUT == (1 << DW_O)) begin : g_none
            assign drop_req[gi] = 1'b0;
        end else begin : g_cmp
            assign drop_req[gi] = !rst_i && input_valid_i[gi] &&
                                  (int'(input_dest_i[gi]) >= NUM_OUTPUT);
        end
    end

    assign drop_o = drop_req;

    always_comb begin
        input_ready_o = drop_req;
        for (int j = 0; j < NUM_OUTPUT; j++) begin
            input_ready_o = input_ready_o | ready_mat[j];
        end
    end

endmodule
